ctrl_spec_tracker: RTL and testbench

Tracks the single in-flight control-transfer instruction (branch/JAL/JALR) through the E, M and W stages of the five-stage RISC-V pipeline. It generates the `speculativeE/M/W` flags that the hazard unit turns into `flushE` bubbles, and carries the resolved next-PC from E to W. When the instruction reaches W, it issues a one-cycle fetch redirect and a Decode flush. It also keeps saturating performance counters for control instructions, taken branches and control-induced bubble cycles.

---
 rtl/ctrl_spec_tracker.sv | 112 +++++++++++
 tb/tb_ctrl_spec_tracker.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_spec_tracker.sv
// Follows the single in-flight branch/JAL/JALR through E/M/W, raises the
// per-stage speculation flags, redirects fetch from W and keeps perf counters.
module ctrl_spec_tracker #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             validD,
  input  logic             isctrlD,
  input  logic             stallD,
  input  logic             flushE,
  input  logic             takenE,
  input  logic [XLEN-1:0]  npcE,
  output logic             speculativeE,
  output logic             speculativeM,
  output logic             speculativeW,
  output logic             redirectW,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flushD,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_rdata
);

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] npc;
  } ctrl_pl_t;

  logic spec_e_q, spec_e_d;
  logic spec_m_q, spec_m_d;
  logic spec_w_q, spec_w_d;
  ctrl_pl_t pl_m_q, pl_m_d;
  ctrl_pl_t pl_w_q, pl_w_d;
  logic [CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic bubble_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    if (inc && !(&v)) return v + {{(CNT_W-1){1'b0}}, 1'b1};
    return v;
  endfunction

  // Any flag set means the instruction presented to E is a wrong-path bubble;
  // a load-use stall is excluded so it is not double-counted as speculation.
  assign bubble_inc = (spec_e_q | spec_m_q | spec_w_q) & ~stallD;

  always_comb begin
    spec_e_d = validD & isctrlD & ~flushE;
    spec_m_d = spec_e_q;
    spec_w_d = spec_m_q;

    pl_m_d = pl_m_q;
    if (spec_e_q) begin
      pl_m_d.taken = takenE;
      pl_m_d.npc   = npcE;
    end
    pl_w_d = pl_w_q;
    if (spec_m_q) pl_w_d = pl_m_q;

    ctrl_cnt_d   = sat_inc(ctrl_cnt_q, spec_w_q);
    taken_cnt_d  = sat_inc(taken_cnt_q, spec_w_q & pl_w_q.taken);
    bubble_cnt_d = sat_inc(bubble_cnt_q, bubble_inc);
    if (cnt_clr) begin
      ctrl_cnt_d   = '0;
      taken_cnt_d  = '0;
      bubble_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spec_e_q     <= 1'b0;
      spec_m_q     <= 1'b0;
      spec_w_q     <= 1'b0;
      pl_m_q       <= '0;
      pl_w_q       <= '0;
      ctrl_cnt_q   <= '0;
      taken_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      spec_e_q     <= spec_e_d;
      spec_m_q     <= spec_m_d;
      spec_w_q     <= spec_w_d;
      pl_m_q       <= pl_m_d;
      pl_w_q       <= pl_w_d;
      ctrl_cnt_q   <= ctrl_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign speculativeE = spec_e_q;
  assign speculativeM = spec_m_q;
  assign speculativeW = spec_w_q;
  assign redirectW    = spec_w_q;
  assign flushD       = spec_w_q;
  assign redirect_pc  = pl_w_q.npc;

  always_comb begin
    cnt_rdata = '0;
    case (cnt_sel)
      2'd0:    cnt_rdata = ctrl_cnt_q;
      2'd1:    cnt_rdata = taken_cnt_q;
      2'd2:    cnt_rdata = bubble_cnt_q;
      default: cnt_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ctrl_spec_tracker.sv
// Directed bench: expected redirects go into a queue that a negedge monitor
// drains whenever the DUT raises redirectW; counters are checked inline.
module tb_ctrl_spec_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        validD, isctrlD, stallD, flush_force, takenE, cnt_clr;
  logic [31:0] npcE;
  logic [1:0]  cnt_sel;
  logic        flushE;
  logic        speculativeE, speculativeM, speculativeW, redirectW, flushD;
  logic [31:0] redirect_pc, cnt_rdata;
  logic        s_specE, s_specM, s_specW, s_redir, s_flushD;
  logic [31:0] s_rpc;
  logic [3:0]  s_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Hazard unit model: any in-flight control instruction flushes E.
  assign flushE = flush_force | speculativeE | speculativeM | speculativeW;

  ctrl_spec_tracker #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .validD(validD), .isctrlD(isctrlD), .stallD(stallD),
    .flushE(flushE), .takenE(takenE), .npcE(npcE),
    .speculativeE(speculativeE), .speculativeM(speculativeM), .speculativeW(speculativeW),
    .redirectW(redirectW), .redirect_pc(redirect_pc), .flushD(flushD),
    .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata)
  );

  ctrl_spec_tracker #(.XLEN(32), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .validD(validD), .isctrlD(isctrlD), .stallD(stallD),
    .flushE(flushE), .takenE(takenE), .npcE(npcE),
    .speculativeE(s_specE), .speculativeM(s_specM), .speculativeW(s_specW),
    .redirectW(s_redir), .redirect_pc(s_rpc), .flushD(s_flushD),
    .cnt_clr(1'b0), .cnt_sel(cnt_sel), .cnt_rdata(s_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string name, input logic [2:0] exp);
    chk(name, {speculativeE, speculativeM, speculativeW}, exp);
  endtask

  task automatic rd(input string name, input logic [1:0] sel, input logic [31:0] exp);
    cnt_sel = sel;
    #1;
    chk(name, cnt_rdata, exp);
  endtask

  task automatic rd_sat(input string name, input logic [1:0] sel, input logic [3:0] exp);
    cnt_sel = sel;
    #1;
    chk(name, s_rdata, exp);
  endtask

  // Presents one control instruction in the next cycle c; redirect due in c+3.
  task automatic run_branch(input logic tk, input logic [31:0] npc, input logic clr_at_w);
    int c;
    tick();
    c = edge_cnt;
    stallD = 1'b0; flush_force = 1'b0; validD = 1'b1; isctrlD = 1'b1;
    exp_q.push_back('{cyc: c + 3, pc: npc});
    @(negedge clk); flags("flags_c0", 3'b000);
    tick();
    validD = 1'b0; isctrlD = 1'b0; takenE = tk; npcE = npc;
    @(negedge clk); flags("flags_c1", 3'b100);
    tick();
    takenE = ~tk; npcE = 32'hdead_beef;
    @(negedge clk); flags("flags_c2", 3'b010);
    tick();
    cnt_clr = clr_at_w;
    @(negedge clk); flags("flags_c3", 3'b001);
    tick();
    cnt_clr = 1'b0;
    @(negedge clk); flags("flags_c4", 3'b000);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (redirectW === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL redirect_unexpected: got pc 0x%0h expected none (cycle %0d)", redirect_pc, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != edge_cnt || redirect_pc !== e.pc || flushD !== 1'b1) begin
          n_err++;
          $display("FAIL redirect: got cycle %0d pc 0x%0h flushD %b expected cycle %0d pc 0x%0h flushD 1",
                   edge_cnt, redirect_pc, flushD, e.cyc, e.pc);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
      e = exp_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL redirect_missed: got none expected pc 0x%0h in cycle %0d", e.pc, e.cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0; validD = 1'b0; isctrlD = 1'b0; stallD = 1'b0; flush_force = 1'b0;
    takenE = 1'b0; cnt_clr = 1'b0; npcE = '0; cnt_sel = 2'd0;

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      validD = 1'($urandom); isctrlD = 1'($urandom); stallD = 1'($urandom);
      takenE = 1'($urandom); npcE = $urandom; cnt_clr = 1'($urandom); cnt_sel = 2'($urandom);
      @(posedge clk);
    end
    #1;
    @(negedge clk);
    flags("rst_flags", 3'b000);
    chk("rst_redirect", {redirectW, flushD}, 2'b00);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_rdata", cnt_rdata, 32'h0);
    tick();
    rst_n = 1'b1; validD = 1'b0; isctrlD = 1'b0; stallD = 1'b0; cnt_clr = 1'b0; cnt_sel = 2'd0;
    tick();
    @(negedge clk);
    flags("post_rst_flags", 3'b000);
    chk("post_rst_rpc", redirect_pc, 32'h0);
    rd("post_rst_ctrl", 2'd0, 0);

    // Taken branch
    run_branch(1'b1, 32'h0000_0100, 1'b0);
    rd("tk_ctrl", 2'd0, 1); rd("tk_taken", 2'd1, 1); rd("tk_bubble", 2'd2, 3);
    rd_sat("sat_ctrl_1", 2'd0, 4'd1);

    // Not-taken branch
    run_branch(1'b0, 32'h0000_0044, 1'b0);
    rd("nt_ctrl", 2'd0, 2); rd("nt_taken", 2'd1, 1); rd("nt_bubble", 2'd2, 6);

    // Load-use stall holds a branch in Decode
    for (int i = 0; i < 3; i++) begin
      tick();
      validD = 1'b1; isctrlD = 1'b1; flush_force = 1'b1; stallD = 1'b1;
      @(negedge clk); flags("stall_flags", 3'b000);
    end
    rd("stall_bubble", 2'd2, 6);
    run_branch(1'b1, 32'h0000_0080, 1'b0);
    rd("stall_ctrl", 2'd0, 3); rd("stall_taken", 2'd1, 2); rd("stall_bubble2", 2'd2, 9);

    // Back-to-back: isctrlD held for 8 cycles
    tick();
    c = edge_cnt;
    exp_q.push_back('{cyc: c + 3, pc: 32'h0000_0204});
    exp_q.push_back('{cyc: c + 7, pc: 32'h0000_0214});
    for (int i = 0; i < 8; i++) begin
      validD = 1'b1; isctrlD = 1'b1; takenE = 1'b1; npcE = 32'h200 + 32'(4 * i);
      tick();
    end
    validD = 1'b0; isctrlD = 1'b0;
    @(negedge clk);
    rd("b2b_ctrl", 2'd0, 5); rd("b2b_taken", 2'd1, 4); rd("b2b_bubble", 2'd2, 15);
    rd("sel3_zero", 2'd3, 0);

    // Reset mid-flight drops the instruction
    tick();
    validD = 1'b1; isctrlD = 1'b1;
    tick();
    validD = 1'b0; isctrlD = 1'b0; takenE = 1'b1; npcE = 32'h300; rst_n = 1'b0;
    @(negedge clk); flags("midrst_e", 3'b100);
    tick();
    rst_n = 1'b1;
    @(negedge clk); flags("midrst_after", 3'b000);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk); flags("midrst_idle", 3'b000);
    end
    rd("midrst_ctrl", 2'd0, 0); rd("midrst_bubble", 2'd2, 0);

    // Preload then clear coinciding with a W redirect
    for (int i = 0; i < 4; i++) run_branch(1'b1, 32'h400 + 32'(16 * i), 1'b0);
    rd("pre_ctrl", 2'd0, 4); rd_sat("sat_pre_ctrl", 2'd0, 4'd4);
    run_branch(1'b1, 32'h0000_0500, 1'b1);
    rd("clr_ctrl", 2'd0, 0); rd("clr_taken", 2'd1, 0); rd("clr_bubble", 2'd2, 0);
    rd_sat("sat_noclr_ctrl", 2'd0, 4'd5);

    // 20 branches: 32-bit counts keep going, 4-bit counts saturate
    for (int i = 0; i < 20; i++) run_branch((i % 2) == 0, 32'h1000 + 32'(8 * i), 1'b0);
    rd("run_ctrl", 2'd0, 20); rd("run_taken", 2'd1, 10); rd("run_bubble", 2'd2, 60);
    rd_sat("sat_ctrl", 2'd0, 4'd15); rd_sat("sat_taken", 2'd1, 4'd15); rd_sat("sat_bubble", 2'd2, 4'd15);

    tick(); tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
